tlk2711_rx_buf_sched: RTL and testbench
=======================================

Name: tlk2711_rx_buf_sched

Overview:
Controller that sequences the TLK2711 RX link across a ring of NUM_BUF DDR frame buffers.
- Issues rx_start with each buffer's base address.
- Counts completed frames per buffer and hands full buffers to the host.
- Drops data when the host has not released the next buffer.
- On link/sync loss, drains the RX FIFO, soft-resets the link and restarts the current buffer.
- Sits between the host register block and the RX link, in the same clk domain.

Parameters:
ADDR_WIDTH, 32, DDR byte address width
NUM_BUF, 4, number of ring buffers (2..16)
BUF_IDX_W, 2, buffer index width, equal to clog2(NUM_BUF)
DRAIN_TIMEOUT, 1024, maximum drain cycles before forcing reset
SRST_CYCLES, 4, soft-reset pulse length in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_enable  in  1  level; run the scheduler
i_base_addr  in  ADDR_WIDTH  buffer 0 address
i_buf_stride  in  ADDR_WIDTH  byte distance between buffers
i_frames_per_buf  in  16  frames per buffer; 0 is treated as 1
i_buf_release  in  1  host returns a buffer (one-cycle pulse)
i_release_idx  in  BUF_IDX_W  index of the returned buffer
i_rx_interrupt  in  1  frame-written pulse from the RX link
i_loss_interrupt  in  1  link/sync loss pulse from the RX link
i_fifo_empty  in  1  RX FIFO empty
o_rx_start  out  1  one-cycle pulse: load base address into the link
o_rx_base_addr  out  ADDR_WIDTH  current buffer address
o_rx_fifo_rd  out  1  drain read strobe
o_soft_rst  out  1  soft reset to the RX link
o_buf_done  out  1  one-cycle pulse: buffer full
o_buf_done_idx  out  BUF_IDX_W  index of the completed buffer
o_cur_idx  out  BUF_IDX_W  buffer currently being written
o_buf_busy  out  NUM_BUF  host-owned buffer mask
o_drop_cnt  out  16  saturating count of dropped buffers
o_loss_cnt  out  16  saturating count of loss recoveries
o_state  out  3  FSM state, for the status register

Behaviour:
- All outputs are registered. On reset every output is 0, state is IDLE, idx is 0 and the frame counter is 0.
- States: IDLE=0, START=1, RUN=2, DRAIN=3, SRST=4.
- IDLE: ignores all interrupts. When i_enable=1, latches base, stride and fpb (0 becomes 1), then goes to START.
- START, one cycle:
  - o_rx_start=1.
  - o_rx_base_addr = base + idx*stride, modulo 2^ADDR_WIDTH. The address is updated in the same cycle as o_rx_start and held until the next START.
  - Clears frame_cnt, then goes to RUN.
- RUN, on i_rx_interrupt:
  - If frame_cnt+1 < fpb: frame_cnt++.
  - Otherwise: next = (idx==NUM_BUF-1) ? 0 : idx+1.
  - If busy[next]=0: set busy[idx], pulse o_buf_done with o_buf_done_idx=idx, set idx<=next, go to START. o_buf_done and o_rx_start are therefore one cycle apart.
  - If busy[next]=1: drop the buffer. o_drop_cnt++, no o_buf_done, idx unchanged, go to START (the buffer is overwritten).
  - A release of next in the same cycle counts as free.
- RUN, i_enable=0: go to IDLE immediately. busy is kept. On re-enable, restart at the current idx.
- Loss: i_loss_interrupt in START or RUN goes to DRAIN with the drain timer cleared. Loss takes priority over a simultaneous i_rx_interrupt; that frame is not counted. Loss in DRAIN or SRST is ignored.
- DRAIN:
  - o_rx_fifo_rd = ~i_fifo_empty (registered from a combinational decode on the current i_fifo_empty).
  - Go to SRST when i_fifo_empty=1 or the timer reaches DRAIN_TIMEOUT-1.
  - i_rx_interrupt is ignored.
- SRST: o_soft_rst=1 for exactly SRST_CYCLES cycles, then o_loss_cnt++ and go to START with the same idx. The partial buffer is discarded.
- Buffer release: i_buf_release clears busy[i_release_idx] in any state. If a set and a clear target the same index in the same cycle, the set wins. Releasing a non-busy index has no effect.
- Both counters saturate at 0xFFFF and clear only on rst.
- Reset mid-operation returns everything to reset values next cycle, including o_soft_rst=0.

Test Plan:
1. NUM_BUF=4, base 0x1000_0000, stride 0x0001_0000, fpb=2, enable → o_rx_start with addr 0x1000_0000. After 2 i_rx_interrupt → o_buf_done idx0, busy=0001; the next cycle o_rx_start with addr 0x1001_0000.
2. Same configuration, no releases, 8 frames → busy=0111 and idx=3. The 4th buffer's last frame sees busy[0] set → drop_cnt=1, no buf_done, o_rx_start again with 0x1003_0000.
3. busy=0111, release idx0 in the same cycle as buf3's final interrupt → o_buf_done idx3, busy=1110, o_rx_start with 0x1000_0000.
4. Loss in RUN with 5 FIFO words → o_rx_fifo_rd high 5 cycles, o_soft_rst high 4 cycles, o_rx_start at the same address, loss_cnt=1, frame_cnt=0.
5. Loss with i_fifo_empty held 0 → drain lasts exactly 1024 cycles, then SRST. A simultaneous interrupt+loss does not advance frame_cnt.
6. fpb=0 → buf_done on every interrupt. Assert rst mid-RUN → all outputs 0 and o_state=0 next cycle.

Source files
------------

// File: rtl/tlk2711_rx_buf_sched.sv
// TLK2711 RX buffer-ring scheduler: walks the RX link through NUM_BUF DDR frame
// buffers, hands full buffers to the host and recovers the link after sync loss.

module tlk2711_rx_buf_sched #(
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_BUF       = 4,
    parameter int BUF_IDX_W     = 2,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SRST_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_buf_stride,
    input  logic [15:0]           i_frames_per_buf,
    input  logic                  i_buf_release,
    input  logic [BUF_IDX_W-1:0]  i_release_idx,
    input  logic                  i_rx_interrupt,
    input  logic                  i_loss_interrupt,
    input  logic                  i_fifo_empty,
    output logic                  o_rx_start,
    output logic [ADDR_WIDTH-1:0] o_rx_base_addr,
    output logic                  o_rx_fifo_rd,
    output logic                  o_soft_rst,
    output logic                  o_buf_done,
    output logic [BUF_IDX_W-1:0]  o_buf_done_idx,
    output logic [BUF_IDX_W-1:0]  o_cur_idx,
    output logic [NUM_BUF-1:0]    o_buf_busy,
    output logic [15:0]           o_drop_cnt,
    output logic [15:0]           o_loss_cnt,
    output logic [2:0]            o_state
);

    localparam int DT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int SR_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SRST  = 3'd4
    } state_t;

    state_t                state;
    logic [BUF_IDX_W-1:0]  idx;
    logic [15:0]           frame_cnt;
    logic [NUM_BUF-1:0]    busy;
    logic [DT_W-1:0]       drain_timer;
    logic [SR_W-1:0]       srst_timer;
    logic [15:0]           drop_cnt;
    logic [15:0]           loss_cnt;

    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] stride_r;
    logic [15:0]           fpb_r;

    logic [BUF_IDX_W-1:0]  next_idx;
    logic [NUM_BUF-1:0]    rel_mask;
    logic [NUM_BUF-1:0]    set_mask;
    logic                  frame_last;
    logic                  next_free;
    logic                  take_buf;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A release of the next buffer in the same cycle as the last frame counts as free.
    always_comb begin
        next_idx   = (idx == BUF_IDX_W'(NUM_BUF - 1)) ? '0 : idx + BUF_IDX_W'(1);
        rel_mask   = '0;
        if (i_buf_release)
            rel_mask[i_release_idx] = 1'b1;
        next_free  = ~busy[next_idx] | rel_mask[next_idx];
        frame_last = ({1'b0, frame_cnt} + 17'd1) >= {1'b0, fpb_r};
        take_buf   = (state == ST_RUN) && i_enable && !i_loss_interrupt &&
                     i_rx_interrupt && frame_last && next_free;
        set_mask   = '0;
        if (take_buf)
            set_mask[idx] = 1'b1;
    end

    // Configuration is sampled once per enable; fpb of 0 behaves as 1.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && i_enable) begin
            base_r   <= i_base_addr;
            stride_r <= i_buf_stride;
            fpb_r    <= (i_frames_per_buf == 16'd0) ? 16'd1 : i_frames_per_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            frame_cnt      <= '0;
            busy           <= '0;
            drain_timer    <= '0;
            srst_timer     <= '0;
            drop_cnt       <= '0;
            loss_cnt       <= '0;
            o_rx_start     <= 1'b0;
            o_rx_base_addr <= '0;
            o_rx_fifo_rd   <= 1'b0;
            o_soft_rst     <= 1'b0;
            o_buf_done     <= 1'b0;
            o_buf_done_idx <= '0;
        end else begin
            o_rx_start   <= 1'b0;
            o_rx_fifo_rd <= 1'b0;
            o_buf_done   <= 1'b0;
            busy         <= (busy & ~rel_mask) | set_mask;

            case (state)
                ST_IDLE: begin
                    if (i_enable)
                        state <= ST_START;
                end

                ST_START: begin
                    frame_cnt <= '0;
                    if (i_loss_interrupt) begin
                        drain_timer <= '0;
                        state       <= ST_DRAIN;
                    end else begin
                        o_rx_start     <= 1'b1;
                        o_rx_base_addr <= base_r + ADDR_WIDTH'(idx) * stride_r;
                        state          <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!i_enable) begin
                        state <= ST_IDLE;
                    end else if (i_loss_interrupt) begin
                        frame_cnt   <= '0;
                        drain_timer <= '0;
                        state       <= ST_DRAIN;
                    end else if (i_rx_interrupt) begin
                        if (!frame_last) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end else if (take_buf) begin
                            o_buf_done     <= 1'b1;
                            o_buf_done_idx <= idx;
                            idx            <= next_idx;
                            state          <= ST_START;
                        end else begin
                            // Host still owns the next buffer: rewrite the current one.
                            drop_cnt <= sat_inc16(drop_cnt);
                            state    <= ST_START;
                        end
                    end
                end

                ST_DRAIN: begin
                    o_rx_fifo_rd <= ~i_fifo_empty;
                    if (i_fifo_empty || drain_timer == DT_W'(DRAIN_TIMEOUT - 1)) begin
                        srst_timer <= '0;
                        o_soft_rst <= 1'b1;
                        state      <= ST_SRST;
                    end else begin
                        drain_timer <= drain_timer + DT_W'(1);
                    end
                end

                ST_SRST: begin
                    if (srst_timer == SR_W'(SRST_CYCLES - 1)) begin
                        o_soft_rst <= 1'b0;
                        loss_cnt   <= sat_inc16(loss_cnt);
                        state      <= ST_START;
                    end else begin
                        srst_timer <= srst_timer + SR_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_cur_idx  = idx;
    assign o_buf_busy = busy;
    assign o_drop_cnt = drop_cnt;
    assign o_loss_cnt = loss_cnt;
    assign o_state    = state;

endmodule

// File: tb/tb_tlk2711_rx_buf_sched.sv
// Bench for tlk2711_rx_buf_sched: directed ring/loss scenarios plus randomized
// frame/release traffic checked against a transaction-level ring model.

module tb_tlk2711_rx_buf_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [31:0] i_base_addr;
    logic [31:0] i_buf_stride;
    logic [15:0] i_frames_per_buf;
    logic        i_buf_release;
    logic [1:0]  i_release_idx;
    logic        i_rx_interrupt;
    logic        i_loss_interrupt;
    logic        i_fifo_empty;
    logic        o_rx_start;
    logic [31:0] o_rx_base_addr;
    logic        o_rx_fifo_rd;
    logic        o_soft_rst;
    logic        o_buf_done;
    logic [1:0]  o_buf_done_idx;
    logic [1:0]  o_cur_idx;
    logic [3:0]  o_buf_busy;
    logic [15:0] o_drop_cnt;
    logic [15:0] o_loss_cnt;
    logic [2:0]  o_state;

    always #5 clk = ~clk;

    tlk2711_rx_buf_sched dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_base_addr(i_base_addr),
        .i_buf_stride(i_buf_stride), .i_frames_per_buf(i_frames_per_buf),
        .i_buf_release(i_buf_release), .i_release_idx(i_release_idx),
        .i_rx_interrupt(i_rx_interrupt), .i_loss_interrupt(i_loss_interrupt),
        .i_fifo_empty(i_fifo_empty), .o_rx_start(o_rx_start),
        .o_rx_base_addr(o_rx_base_addr), .o_rx_fifo_rd(o_rx_fifo_rd),
        .o_soft_rst(o_soft_rst), .o_buf_done(o_buf_done),
        .o_buf_done_idx(o_buf_done_idx), .o_cur_idx(o_cur_idx),
        .o_buf_busy(o_buf_busy), .o_drop_cnt(o_drop_cnt),
        .o_loss_cnt(o_loss_cnt), .o_state(o_state)
    );

    logic [78:0] all_out;
    assign all_out = {o_rx_start, o_rx_base_addr, o_rx_fifo_rd, o_soft_rst, o_buf_done,
                      o_buf_done_idx, o_cur_idx, o_buf_busy, o_drop_cnt, o_loss_cnt, o_state};

    int checks   = 0;
    int failures = 0;

    // Ring model: which buffer is filling, which ones the host holds, frames so far.
    logic [31:0] m_base, m_stride;
    int          m_fpb, m_frames;
    logic [1:0]  m_idx;
    logic [3:0]  m_busy;
    logic [15:0] m_drop, m_loss;

    task automatic model_frame(input bit rel, input logic [1:0] ridx, output bit d,
                               output logic [1:0] di, output bit st, output logic [31:0] a);
        logic [1:0] nxt;
        bit         free;
        d = 0; di = '0; st = 0; a = '0;
        nxt  = m_idx + 2'd1;
        free = !m_busy[nxt] || (rel && ridx == nxt);
        if (rel) m_busy[ridx] = 1'b0;
        m_frames++;
        if (m_frames >= m_fpb) begin
            m_frames = 0;
            st = 1;
            if (free) begin
                d = 1; di = m_idx;
                m_busy[m_idx] = 1'b1;
                m_idx = nxt;
            end else if (m_drop != 16'hFFFF) begin
                m_drop++;
            end
            a = m_base + m_stride * 32'(m_idx);
        end
    endtask

    task automatic send_frame(input bit rel, input logic [1:0] ridx, output bit d,
                              output logic [1:0] di, output bit st, output logic [31:0] a);
        int guard = 0;
        d = 0; di = '0; st = 0; a = '0;
        while (o_state !== 3'd2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; failures++;
            $display("FAIL run_wait: state=%0d required=2", o_state);
        end
        i_rx_interrupt = 1'b1; i_buf_release = rel; i_release_idx = ridx;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_rx_interrupt = 1'b0; i_buf_release = 1'b0;
            if (o_buf_done) begin d = 1; di = o_buf_done_idx; end
            if (o_rx_start) begin st = 1; a = o_rx_base_addr; end
        end
    endtask

    task automatic wait_rx_start(output bit got, output logic [31:0] a);
        got = 0; a = '0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_rx_start) begin got = 1; a = o_rx_base_addr; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_outputs: got %h required 0", all_out); end
        rst = 1'b0;
        i_rx_interrupt = 1'b1; i_loss_interrupt = 1'b1;
        @(negedge clk);
        i_rx_interrupt = 1'b0; i_loss_interrupt = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL idle_ignores_irq: got %h required 0", all_out); end
        m_idx = 0; m_busy = 0; m_frames = 0; m_drop = 0; m_loss = 0;
    endtask

    task automatic test_first_buffer();
        bit got, d, ed, st, est;
        logic [1:0] di, edi;
        logic [31:0] a, ea;
        i_base_addr = 32'h1000_0000; i_buf_stride = 32'h0001_0000; i_frames_per_buf = 16'd2;
        m_base = 32'h1000_0000; m_stride = 32'h0001_0000; m_fpb = 2;
        i_enable = 1'b1;
        wait_rx_start(got, a);
        checks++;
        if (!got || a !== 32'h1000_0000) begin failures++; $display("FAIL first_start: got %0b addr %h required 1 addr 10000000", got, a); end
        for (int f = 0; f < 2; f++) begin
            send_frame(1'b0, 2'd0, d, di, st, a);
            model_frame(1'b0, 2'd0, ed, edi, est, ea);
            checks++;
            if (d !== ed || (ed && di !== edi)) begin failures++; $display("FAIL first_done f%0d: got %0b idx %0d required %0b idx %0d", f, d, di, ed, edi); end
            checks++;
            if (st !== est || (est && a !== ea)) begin failures++; $display("FAIL first_restart f%0d: got %0b addr %h required %0b addr %h", f, st, a, est, ea); end
        end
        checks++;
        if (o_buf_busy !== 4'b0001 || a !== 32'h1001_0000) begin failures++; $display("FAIL first_busy: got busy %b addr %h required 0001 addr 10010000", o_buf_busy, a); end
    endtask

    task automatic test_ring_fill_drop();
        bit d, ed, st, est;
        logic [1:0] di, edi;
        logic [31:0] a, ea;
        for (int f = 2; f < 8; f++) begin
            send_frame(1'b0, 2'd0, d, di, st, a);
            model_frame(1'b0, 2'd0, ed, edi, est, ea);
            checks++;
            if (d !== ed || (ed && di !== edi)) begin failures++; $display("FAIL ring_done f%0d: got %0b idx %0d required %0b idx %0d", f, d, di, ed, edi); end
            checks++;
            if (st !== est || (est && a !== ea)) begin failures++; $display("FAIL ring_start f%0d: got %0b addr %h required %0b addr %h", f, st, a, est, ea); end
            checks++;
            if (o_buf_busy !== m_busy || o_cur_idx !== m_idx) begin failures++; $display("FAIL ring_state f%0d: got busy %b idx %0d required %b idx %0d", f, o_buf_busy, o_cur_idx, m_busy, m_idx); end
        end
        checks++;
        if (o_buf_busy !== 4'b0111 || o_cur_idx !== 2'd3 || o_drop_cnt !== 16'd1 || a !== 32'h1003_0000)
            begin failures++; $display("FAIL ring_drop: got busy %b idx %0d drop %0d addr %h required 0111 3 1 10030000", o_buf_busy, o_cur_idx, o_drop_cnt, a); end
    endtask

    task automatic test_release_same_cycle();
        bit d, ed, st, est;
        logic [1:0] di, edi;
        logic [31:0] a, ea;
        for (int f = 0; f < 2; f++) begin
            send_frame(f == 1, 2'd0, d, di, st, a);
            model_frame(f == 1, 2'd0, ed, edi, est, ea);
            checks++;
            if (d !== ed || (ed && di !== edi)) begin failures++; $display("FAIL rel_done f%0d: got %0b idx %0d required %0b idx %0d", f, d, di, ed, edi); end
        end
        checks++;
        if (!d || di !== 2'd3 || o_buf_busy !== 4'b1110 || !st || a !== 32'h1000_0000)
            begin failures++; $display("FAIL rel_same_cycle: got done %0b idx %0d busy %b addr %h required 1 3 1110 10000000", d, di, o_buf_busy, a); end
    endtask

    task automatic test_loss_drain();
        bit d, ed, st, est, got;
        logic [1:0] di, edi;
        logic [31:0] a, ea;
        int words, rd, sr;
        send_frame(1'b0, 2'd0, d, di, st, a);
        model_frame(1'b0, 2'd0, ed, edi, est, ea);
        // FIFO pops one word for every DRAIN cycle in which it reports non-empty.
        words = 5; rd = 0; sr = 0; got = 0;
        i_loss_interrupt = 1'b1; i_fifo_empty = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            i_loss_interrupt = 1'b0;
            if (o_rx_fifo_rd) rd++;
            if (o_soft_rst) sr++;
            if (o_rx_start) begin got = 1; a = o_rx_base_addr; end
            i_fifo_empty = (words == 0);
            if (o_state == 3'd3 && words > 0) words--;
        end
        i_fifo_empty = 1'b1;
        m_frames = 0; m_loss++;
        ea = m_base + m_stride * 32'(m_idx);
        checks++;
        if (rd != 5) begin failures++; $display("FAIL drain_reads: got %0d required 5", rd); end
        checks++;
        if (sr != 4) begin failures++; $display("FAIL srst_len: got %0d required 4", sr); end
        checks++;
        if (!got || a !== ea || o_loss_cnt !== m_loss) begin failures++; $display("FAIL loss_restart: got %0b addr %h loss %0d required 1 %h %0d", got, a, o_loss_cnt, ea, m_loss); end
        for (int f = 0; f < 2; f++) begin
            send_frame(1'b0, 2'd0, d, di, st, a);
            model_frame(1'b0, 2'd0, ed, edi, est, ea);
            checks++;
            if (d !== ed || st !== est || (est && a !== ea) || o_drop_cnt !== m_drop)
                begin failures++; $display("FAIL post_loss f%0d: got %0b %0b %h drop %0d required %0b %0b %h drop %0d", f, d, st, a, o_drop_cnt, ed, est, ea, m_drop); end
        end
    endtask

    task automatic test_drain_timeout();
        bit d, ed, st, est, got, done_seen;
        logic [1:0] di, edi;
        logic [31:0] a, ea;
        int drain, rd, sr;
        send_frame(1'b0, 2'd0, d, di, st, a);
        model_frame(1'b0, 2'd0, ed, edi, est, ea);
        drain = 0; rd = 0; sr = 0; got = 0; done_seen = 0;
        i_rx_interrupt = 1'b1; i_loss_interrupt = 1'b1; i_fifo_empty = 1'b0;
        for (int c = 0; c < 1500 && !got; c++) begin
            @(negedge clk);
            i_rx_interrupt = 1'b0; i_loss_interrupt = 1'b0;
            if (o_state == 3'd3) drain++;
            if (o_rx_fifo_rd) rd++;
            if (o_soft_rst) sr++;
            if (o_buf_done) done_seen = 1;
            if (o_rx_start) begin got = 1; a = o_rx_base_addr; end
        end
        i_fifo_empty = 1'b1;
        m_frames = 0; m_loss++;
        ea = m_base + m_stride * 32'(m_idx);
        checks++;
        if (drain != 1024 || rd != 1024) begin failures++; $display("FAIL drain_timeout: got %0d cycles %0d reads required 1024 1024", drain, rd); end
        checks++;
        if (sr != 4) begin failures++; $display("FAIL timeout_srst_len: got %0d required 4", sr); end
        checks++;
        if (done_seen || o_drop_cnt !== m_drop) begin failures++; $display("FAIL loss_priority: got done %0b drop %0d required 0 %0d", done_seen, o_drop_cnt, m_drop); end
        checks++;
        if (!got || a !== ea || o_loss_cnt !== m_loss) begin failures++; $display("FAIL timeout_restart: got %0b addr %h loss %0d required 1 %h %0d", got, a, o_loss_cnt, ea, m_loss); end
    endtask

    task automatic test_fpb0_random();
        bit d, ed, st, est, got, rel;
        logic [1:0] di, edi, r;
        logic [31:0] a, ea;
        i_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (o_state !== 3'd0 || o_buf_busy !== m_busy) begin failures++; $display("FAIL disable_idle: got state %0d busy %b required 0 %b", o_state, o_buf_busy, m_busy); end
        i_buf_release = 1'b1; i_release_idx = 2'd1;
        @(negedge clk);
        i_buf_release = 1'b0; m_busy[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (o_buf_busy !== m_busy) begin failures++; $display("FAIL idle_release: got %b required %b", o_buf_busy, m_busy); end
        m_base = $urandom; m_stride = $urandom; m_fpb = 1; m_frames = 0;
        i_base_addr = m_base; i_buf_stride = m_stride; i_frames_per_buf = 16'd0;
        i_enable = 1'b1;
        wait_rx_start(got, a);
        ea = m_base + m_stride * 32'(m_idx);
        checks++;
        if (!got || a !== ea) begin failures++; $display("FAIL reenable_start: got %0b addr %h required 1 %h", got, a, ea); end
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 2'($urandom_range(0, 3));
                i_buf_release = 1'b1; i_release_idx = r;
                @(negedge clk);
                i_buf_release = 1'b0; m_busy[r] = 1'b0;
            end
            rel = 1'($urandom_range(0, 1));
            r   = 2'($urandom_range(0, 3));
            send_frame(rel, r, d, di, st, a);
            model_frame(rel, r, ed, edi, est, ea);
            checks++;
            if (d !== ed || (ed && di !== edi) || st !== est || (est && a !== ea))
                begin failures++; $display("FAIL rand_frame f%0d: got %0b/%0d %0b/%h required %0b/%0d %0b/%h", f, d, di, st, a, ed, edi, est, ea); end
            checks++;
            if (o_buf_busy !== m_busy || o_cur_idx !== m_idx || o_drop_cnt !== m_drop)
                begin failures++; $display("FAIL rand_state f%0d: got %b %0d %0d required %b %0d %0d", f, o_buf_busy, o_cur_idx, o_drop_cnt, m_busy, m_idx, m_drop); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit got;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_mid_run: got %h required 0", all_out); end
        rst = 1'b0;
        for (int c = 0; c < 20 && o_state !== 3'd2; c++) @(negedge clk);
        i_loss_interrupt = 1'b1; i_fifo_empty = 1'b1; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            i_loss_interrupt = 1'b0;
            if (o_soft_rst) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL srst_reach: got 0 required 1"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_mid_srst: got %h required 0", all_out); end
        rst = 1'b0; i_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_enable = 1'b0; i_base_addr = '0; i_buf_stride = '0;
        i_frames_per_buf = '0; i_buf_release = 1'b0; i_release_idx = '0;
        i_rx_interrupt = 1'b0; i_loss_interrupt = 1'b0; i_fifo_empty = 1'b1;
        test_reset();
        test_first_buffer();
        test_ring_fill_drop();
        test_release_same_cycle();
        test_loss_drain();
        test_drain_timeout();
        test_fpb0_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
